// File: rtl/dvi_pkg.sv
// Shared DVI definitions: TMDS control tokens, pipeline latency, popcount helper
// and the 1280x720p60 timing generator constants.
package dvi_pkg;

   localparam int unsigned TMDS_LATENCY = 2;

   localparam logic [9:0] CTRL_TOKEN_00 = 10'h354;
   localparam logic [9:0] CTRL_TOKEN_01 = 10'h0AB;
   localparam logic [9:0] CTRL_TOKEN_10 = 10'h154;
   localparam logic [9:0] CTRL_TOKEN_11 = 10'h2AB;

   localparam int unsigned H_ACTIVE = 1280;
   localparam int unsigned H_FRONT  = 110;
   localparam int unsigned H_SYNC   = 40;
   localparam int unsigned H_BACK   = 220;
   localparam int unsigned V_ACTIVE = 720;
   localparam int unsigned V_FRONT  = 5;
   localparam int unsigned V_SYNC   = 5;
   localparam int unsigned V_BACK   = 20;

   typedef enum logic [1:0] {
      CTRL_00 = 2'b00,
      CTRL_01 = 2'b01,
      CTRL_10 = 2'b10,
      CTRL_11 = 2'b11
   } ctrl_sel_e;

   function automatic logic [9:0] ctrl_token(input logic c1, input logic c0);
      ctrl_sel_e sel;
      sel = ctrl_sel_e'({c1, c0});
      case (sel)
         CTRL_00: return CTRL_TOKEN_00;
         CTRL_01: return CTRL_TOKEN_01;
         CTRL_10: return CTRL_TOKEN_10;
         default: return CTRL_TOKEN_11;
      endcase
   endfunction

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++)
         n = n + {3'b000, v[i]};
      return n;
   endfunction

endpackage

// File: rtl/tmds_channel_encode.sv
// One TMDS channel: stage 1 builds the 9-bit transition-minimised word,
// stage 2 applies DC balancing against the running disparity or emits a control token.
module tmds_channel_encode
   import dvi_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       de,
   input  logic [7:0] d,
   input  logic       c0,
   input  logic       c1,
   output logic [9:0] q
);

   logic [3:0]        w_n1;
   logic              w_use_xnor;
   logic [8:0]        w_qm;

   logic              r_de_p1;
   logic              r_c0_p1;
   logic              r_c1_p1;
   logic [8:0]        r_qm_p1;

   logic [3:0]        w_n1q;
   logic signed [5:0] w_diff;
   logic signed [5:0] w_cnt;
   logic signed [5:0] w_cnt_next;
   logic [9:0]        w_q;

   logic signed [4:0] r_cnt_p2;
   logic [9:0]        r_q_p2;

   // Stage 1: transition-minimised word
   always_comb begin
      w_n1       = popcount8(d);
      w_use_xnor = (w_n1 > 4'd4) || ((w_n1 == 4'd4) && !d[0]);
      w_qm       = '0;
      w_qm[0]    = d[0];
      for (int i = 1; i < 8; i++)
         w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ d[i]) : (w_qm[i-1] ^ d[i]);
      w_qm[8]    = ~w_use_xnor;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_de_p1 <= 1'b0;
         r_c0_p1 <= 1'b0;
         r_c1_p1 <= 1'b0;
         r_qm_p1 <= '0;
      end else begin
         r_de_p1 <= de;
         r_c0_p1 <= c0;
         r_c1_p1 <= c1;
         r_qm_p1 <= w_qm;
      end
   end

   // Stage 2: DC balance; w_diff is n1q - n0q = 2*n1q - 8, 6-bit signed avoids wrap
   always_comb begin
      w_n1q      = popcount8(r_qm_p1[7:0]);
      w_diff     = $signed({1'b0, w_n1q, 1'b0}) - 6'sd8;
      w_cnt      = {r_cnt_p2[4], r_cnt_p2};
      w_q        = ctrl_token(r_c1_p1, r_c0_p1);
      w_cnt_next = 6'sd0;
      if (r_de_p1) begin
         if ((r_cnt_p2 == 5'sd0) || (w_diff == 6'sd0)) begin
            w_q        = {~r_qm_p1[8], r_qm_p1[8], r_qm_p1[8] ? r_qm_p1[7:0] : ~r_qm_p1[7:0]};
            w_cnt_next = r_qm_p1[8] ? (w_cnt + w_diff) : (w_cnt - w_diff);
         end else if (((r_cnt_p2 > 5'sd0) && (w_diff > 6'sd0)) ||
                      ((r_cnt_p2 < 5'sd0) && (w_diff < 6'sd0))) begin
            w_q        = {1'b1, r_qm_p1[8], ~r_qm_p1[7:0]};
            w_cnt_next = w_cnt + (r_qm_p1[8] ? 6'sd2 : 6'sd0) - w_diff;
         end else begin
            w_q        = {1'b0, r_qm_p1[8], r_qm_p1[7:0]};
            w_cnt_next = w_cnt + w_diff - (r_qm_p1[8] ? 6'sd0 : 6'sd2);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt_p2 <= 5'sd0;
         r_q_p2   <= CTRL_TOKEN_00;
      end else begin
         r_cnt_p2 <= w_cnt_next[4:0];
         r_q_p2   <= w_q;
      end
   end

   assign q = r_q_p2;

endmodule

// File: rtl/dvi_tmds_encode.sv
// Three-channel DVI TMDS encoder, 2-cycle fixed latency; sync levels ride
// on the blue channel's control tokens.
module dvi_tmds_encode
   import dvi_pkg::*;
#(
   parameter bit INVERT_SYNC = 1'b0
)
(
   input  logic       clock,
   input  logic       reset,
   input  logic       de,
   input  logic [7:0] red,
   input  logic [7:0] green,
   input  logic [7:0] blue,
   input  logic       hsync,
   input  logic       vsync,
   output logic [9:0] tmds_red,
   output logic [9:0] tmds_green,
   output logic [9:0] tmds_blue
);

   logic w_hsync;
   logic w_vsync;

   assign w_hsync = hsync ^ INVERT_SYNC;
   assign w_vsync = vsync ^ INVERT_SYNC;

   tmds_channel_encode u_red (
      .clock (clock),
      .reset (reset),
      .de    (de),
      .d     (red),
      .c0    (1'b0),
      .c1    (1'b0),
      .q     (tmds_red)
   );

   tmds_channel_encode u_green (
      .clock (clock),
      .reset (reset),
      .de    (de),
      .d     (green),
      .c0    (1'b0),
      .c1    (1'b0),
      .q     (tmds_green)
   );

   tmds_channel_encode u_blue (
      .clock (clock),
      .reset (reset),
      .de    (de),
      .d     (blue),
      .c0    (w_hsync),
      .c1    (w_vsync),
      .q     (tmds_blue)
   );

endmodule

// File: tb/tb_dvi_tmds_encode.sv
// Directed-vector and reference-model bench for dvi_tmds_encode.
module tb_dvi_tmds_encode;

   logic       clock = 1'b0;
   logic       reset;
   logic       de;
   logic [7:0] red, green, blue;
   logic       hsync, vsync;
   logic [9:0] tmds_red, tmds_green, tmds_blue;

   int n_tests = 0;
   int n_fail  = 0;

   dvi_tmds_encode #(.INVERT_SYNC(1'b0)) u_dut (
      .clock      (clock),
      .reset      (reset),
      .de         (de),
      .red        (red),
      .green      (green),
      .blue       (blue),
      .hsync      (hsync),
      .vsync      (vsync),
      .tmds_red   (tmds_red),
      .tmds_green (tmds_green),
      .tmds_blue  (tmds_blue)
   );

   always #5 clock = ~clock;

   typedef struct {
      string      name;
      logic       de;
      logic [7:0] r, g, b;
      logic       hs, vs;
      logic [9:0] er, eg, eb;
   } vec_t;

   vec_t tbl[10];

   task automatic step(input logic de_i, input logic [7:0] r_i, input logic [7:0] g_i,
                       input logic [7:0] b_i, input logic hs_i, input logic vs_i);
      de = de_i; red = r_i; green = g_i; blue = b_i; hsync = hs_i; vsync = vs_i;
      @(posedge clock);
      #1;
   endtask

   task automatic blank();
      step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 10'h%03h, expected 10'h%03h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk3(input string name, input logic [9:0] er, input logic [9:0] eg,
                       input logic [9:0] eb);
      chk({name, "_red"},   tmds_red,   er);
      chk({name, "_green"}, tmds_green, eg);
      chk({name, "_blue"},  tmds_blue,  eb);
   endtask

   function automatic logic [9:0] ref_token(input logic c1, input logic c0);
      case ({c1, c0})
         2'b00:   return 10'h354;
         2'b01:   return 10'h0AB;
         2'b10:   return 10'h154;
         default: return 10'h2AB;
      endcase
   endfunction

   // Behavioural encoder straight from the TMDS algorithm, integer disparity
   function automatic logic [9:0] ref_enc(input logic de_i, input logic [7:0] d,
                                          input logic c0, input logic c1,
                                          input int cnt_in, output int cnt_out);
      int         n1, n1q, n0q;
      bit         use_xnor;
      logic [8:0] qm;
      logic [9:0] s;
      if (!de_i) begin
         cnt_out = 0;
         return ref_token(c1, c0);
      end
      n1       = $countones(d);
      use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
      qm[0]    = d[0];
      for (int i = 1; i < 8; i++)
         qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = use_xnor ? 1'b0 : 1'b1;
      n1q   = $countones(qm[7:0]);
      n0q   = 8 - n1q;
      if (cnt_in == 0 || n1q == n0q) begin
         s       = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         cnt_out = cnt_in + (qm[8] ? (n1q - n0q) : (n0q - n1q));
      end else if ((cnt_in > 0 && n1q > n0q) || (cnt_in < 0 && n0q > n1q)) begin
         s       = {1'b1, qm[8], ~qm[7:0]};
         cnt_out = cnt_in + (qm[8] ? 2 : 0) + (n0q - n1q);
      end else begin
         s       = {1'b0, qm[8], qm[7:0]};
         cnt_out = cnt_in + (n1q - n0q) - (qm[8] ? 0 : 2);
      end
      return s;
   endfunction

   function automatic logic [7:0] tmds_decode(input logic [9:0] s);
      logic [7:0] b, d;
      b    = s[9] ? ~s[7:0] : s[7:0];
      d[0] = b[0];
      for (int i = 1; i < 8; i++)
         d[i] = s[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
      return d;
   endfunction

   function automatic logic [7:0] pick_pixel();
      case ($urandom_range(0, 3))
         0:       return 8'h00;
         1:       return 8'hFF;
         default: return 8'($urandom);
      endcase
   endfunction

   function automatic int dut_cnt(input int ch);
      case (ch)
         0:       return int'(u_dut.u_red.r_cnt_p2);
         1:       return int'(u_dut.u_green.r_cnt_p2);
         default: return int'(u_dut.u_blue.r_cnt_p2);
      endcase
   endfunction

   initial begin
      logic [9:0] e_prev[3];
      logic [9:0] e_now[3];
      logic [9:0] act[3];
      logic [7:0] d_now[3];
      logic [7:0] d_prev[3];
      int         mc[3];
      int         c_prev[3];
      int         c_tmp;
      logic       de_i, de_prev, hs_i, vs_i;
      int         dc;

      tbl[0] = '{"ctl_hs",    1'b0, 8'hFF, 8'h5A, 8'h33, 1'b1, 1'b0, 10'h354, 10'h354, 10'h0AB};
      tbl[1] = '{"ctl_hs_vs", 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 10'h354, 10'h354, 10'h2AB};
      tbl[2] = '{"ctl_vs",    1'b0, 8'h12, 8'h34, 8'h56, 1'b0, 1'b1, 10'h354, 10'h354, 10'h154};
      tbl[3] = '{"ctl_none",  1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 10'h354, 10'h354, 10'h354};
      tbl[4] = '{"px_00",     1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 10'h100, 10'h100, 10'h100};
      tbl[5] = '{"px_ff",     1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 10'h200, 10'h200, 10'h200};
      tbl[6] = '{"px_01_80_0f", 1'b1, 8'h01, 8'h80, 8'h0F, 1'b0, 1'b0, 10'h1FF, 10'h180, 10'h105};
      tbl[7] = '{"px_f0_55_aa", 1'b1, 8'hF0, 8'h55, 8'hAA, 1'b1, 1'b1, 10'h205, 10'h133, 10'h233};
      tbl[8] = '{"px_55_aa_f0", 1'b1, 8'h55, 8'hAA, 8'hF0, 1'b0, 1'b0, 10'h133, 10'h233, 10'h205};
      tbl[9] = '{"px_0f_01_80", 1'b1, 8'h0F, 8'h01, 8'h80, 1'b1, 1'b0, 10'h105, 10'h1FF, 10'h180};

      // Reset held for three cycles
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'hA5, 8'h5A, 8'hC3, 1'b1, 1'b1);
         chk3($sformatf("reset_c%0d", i), 10'h354, 10'h354, 10'h354);
      end
      reset = 1'b0;
      blank();
      blank();

      // Single symbols, each framed by blanking so cnt starts at 0
      for (int i = 0; i < 10; i++) begin
         blank();
         step(tbl[i].de, tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].hs, tbl[i].vs);
         blank();
         chk3(tbl[i].name, tbl[i].er, tbl[i].eg, tbl[i].eb);
      end

      // Two zero pixels: disparity -8 then +2
      blank();
      step(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      step(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      chk3("zero_px0", 10'h100, 10'h100, 10'h100);
      chk_int("zero_cnt0", dut_cnt(2), -8);
      blank();
      chk3("zero_px1", 10'h3FF, 10'h3FF, 10'h3FF);
      chk_int("zero_cnt1", dut_cnt(2), 2);

      // Two 0xFF pixels: disparity -8 then -2
      blank();
      step(1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
      step(1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
      chk3("ones_px0", 10'h200, 10'h200, 10'h200);
      chk_int("ones_cnt0", dut_cnt(0), -8);
      blank();
      chk3("ones_px1", 10'h0FF, 10'h0FF, 10'h0FF);
      chk_int("ones_cnt1", dut_cnt(0), -2);

      // Blanking between pixels clears the disparity
      blank();
      step(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      blank();
      chk3("gap_px0", 10'h100, 10'h100, 10'h100);
      step(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      chk3("gap_ctl", 10'h354, 10'h354, 10'h354);
      blank();
      chk3("gap_px1", 10'h100, 10'h100, 10'h100);

      // Random 1280-pixel line against the reference model
      for (int ch = 0; ch < 3; ch++) mc[ch] = 0;
      de_prev = 1'b0;
      for (int px = -1; px <= 1281; px++) begin
         de_i = (px >= 0 && px < 1280);
         hs_i = 1'($urandom);
         vs_i = 1'($urandom);
         for (int ch = 0; ch < 3; ch++) d_now[ch] = pick_pixel();
         for (int ch = 0; ch < 3; ch++) begin
            e_now[ch] = ref_enc(de_i, d_now[ch], (ch == 2) ? hs_i : 1'b0,
                                (ch == 2) ? vs_i : 1'b0, mc[ch], c_tmp);
            mc[ch] = c_tmp;
         end
         step(de_i, d_now[0], d_now[1], d_now[2], hs_i, vs_i);
         if (px > -1) begin
            act[0] = tmds_red; act[1] = tmds_green; act[2] = tmds_blue;
            for (int ch = 0; ch < 3; ch++) begin
               chk($sformatf("line_px%0d_ch%0d", px - 1, ch), act[ch], e_prev[ch]);
               dc = dut_cnt(ch);
               chk_int($sformatf("line_cnt%0d_ch%0d", px - 1, ch), dc, c_prev[ch]);
               chk_int($sformatf("line_bound%0d_ch%0d", px - 1, ch),
                       (dc >= -10 && dc <= 10) ? 1 : 0, 1);
               if (de_prev)
                  chk($sformatf("line_dec%0d_ch%0d", px - 1, ch),
                      {2'b00, tmds_decode(act[ch])}, {2'b00, d_prev[ch]});
            end
         end
         for (int ch = 0; ch < 3; ch++) begin
            e_prev[ch] = e_now[ch];
            c_prev[ch] = mc[ch];
            d_prev[ch] = d_now[ch];
         end
         de_prev = de_i;
      end

      // Reset mid-line discards in-flight pixels
      blank();
      for (int i = 0; i < 7; i++)
         step(1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
      reset = 1'b1;
      step(1'b1, 8'hFF, 8'h00, 8'h0F, 1'b1, 1'b1);
      chk3("midrst_c0", 10'h354, 10'h354, 10'h354);
      chk_int("midrst_cnt", dut_cnt(2), 0);
      step(1'b1, 8'h00, 8'hFF, 8'h01, 1'b1, 1'b1);
      chk3("midrst_c1", 10'h354, 10'h354, 10'h354);
      reset = 1'b0;
      step(1'b1, 8'h01, 8'h80, 8'h0F, 1'b1, 1'b0);
      chk3("postrst_c1", 10'h354, 10'h354, 10'h354);
      blank();
      chk3("postrst_c2", 10'h1FF, 10'h180, 10'h105);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
